// File: rtl/sopc_2_pio_in.sv
// Avalon-MM input PIO: synchronized input bus, edge capture with level interrupt.
// Build option SOPC_PIO_IN_BIT_CLEAR_EN selects per-bit clear of edge_capture.
module sopc_2_pio_in #(
    parameter int WIDTH       = 17,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic             read_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);

    localparam int              PRIME_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]   sync_r [SYNC_STAGES];
    logic [WIDTH-1:0]   data_in_s;
    logic [WIDTH-1:0]   prev_r;
    logic [WIDTH-1:0]   edge_capture_r;
    logic [WIDTH-1:0]   irq_mask_r;
    logic [PRIME_W-1:0] prime_cnt_r;
    logic               primed_s;
    logic [WIDTH-1:0]   rise_s;
    logic [WIDTH-1:0]   fall_s;
    logic [WIDTH-1:0]   edge_raw_s;
    logic [WIDTH-1:0]   edge_s;
    logic [WIDTH-1:0]   clr_s;
    logic               wr_s;
    logic               rd_s;
    logic [31:0]        rd_mux_s;
    logic [31:0]        readdata_r;
    logic               irq_r;
    logic               unused_s;

    assign data_in_s = sync_r[SYNC_STAGES-1];
    assign wr_s      = chipselect & ~write_n;
    assign rd_s      = chipselect & ~read_n;
    assign rise_s    = data_in_s & ~prev_r;
    assign fall_s    = ~data_in_s & prev_r;
    assign primed_s  = (prime_cnt_r == PRIME_DONE);
    assign unused_s  = ^writedata;

    // Synchronizer chain; the last stage is the sampled data value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // One-cycle delayed copy of the synchronized data for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r <= {WIDTH{1'b0}};
        end else begin
            prev_r <= data_in_s;
        end
    end

    // Priming counter: holds off edge detection until the chain and prev hold real input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt_r <= {PRIME_W{1'b0}};
        end else if (!primed_s) begin
            prime_cnt_r <= prime_cnt_r + PRIME_W'(1);
        end else begin
            prime_cnt_r <= prime_cnt_r;
        end
    end

    // Edge polarity selection, gated off while priming.
    always_comb begin
        edge_raw_s = {WIDTH{1'b0}};
        case (EDGE_SEL)
            2'd0:    edge_raw_s = rise_s;
            2'd1:    edge_raw_s = fall_s;
            2'd2:    edge_raw_s = rise_s | fall_s;
            default: edge_raw_s = rise_s;
        endcase
        if (primed_s) begin
            edge_s = edge_raw_s;
        end else begin
            edge_s = {WIDTH{1'b0}};
        end
    end

    // Clear vector for edge_capture writes.
    always_comb begin
        clr_s = {WIDTH{1'b0}};
        if (wr_s && (address == ADDR_EDGE)) begin
`ifdef SOPC_PIO_IN_BIT_CLEAR_EN
            clr_s = writedata[WIDTH-1:0];
`else
            clr_s = {WIDTH{1'b1}};
`endif
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // Edge capture: a new edge wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture_r <= {WIDTH{1'b0}};
        end else begin
            edge_capture_r <= (edge_capture_r & ~clr_s) | edge_s;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_r <= {WIDTH{1'b0}};
        end else if (wr_s && (address == ADDR_MASK)) begin
            irq_mask_r <= writedata[WIDTH-1:0];
        end else begin
            irq_mask_r <= irq_mask_r;
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(edge_capture_r & irq_mask_r);
        end
    end

    // Read mux; values are taken before any same-cycle write lands.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_DATA: rd_mux_s[WIDTH-1:0] = data_in_s;
            ADDR_RSVD: rd_mux_s = 32'd0;
            ADDR_MASK: rd_mux_s[WIDTH-1:0] = irq_mask_r;
            ADDR_EDGE: rd_mux_s[WIDTH-1:0] = edge_capture_r;
            default:   rd_mux_s = 32'd0;
        endcase
    end

    // Read data register, updated only on a read strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else if (rd_s) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_sopc_2_pio_in.sv
// Scoreboard bench for sopc_2_pio_in: one rising-edge and one any-edge instance.
module tb_sopc_2_pio_in;

    localparam int SYNC = 2;
`ifdef SOPC_PIO_IN_BIT_CLEAR_EN
    localparam logic [31:0] T4_EXP = 32'h0000_0008;
`else
    localparam logic [31:0] T4_EXP = 32'h0000_0000;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs0;
    logic        cs2;
    logic        write_n;
    logic [31:0] writedata;
    logic        read_n;
    logic [16:0] in0;
    logic [16:0] in2;
    logic [31:0] rd0;
    logic [31:0] rd2;
    logic        irq0;
    logic        irq2;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    bit          sel_q [$];
    string       tag_q [$];

    sopc_2_pio_in #(.WIDTH(17), .SYNC_STAGES(SYNC), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .read_n(read_n),
        .in_port(in0), .readdata(rd0), .irq(irq0)
    );

    sopc_2_pio_in #(.WIDTH(17), .SYNC_STAGES(SYNC), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
        .write_n(write_n), .writedata(writedata), .read_n(read_n),
        .in_port(in2), .readdata(rd2), .irq(irq2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cs0 = ~sel; cs2 = sel; address = a; writedata = d; write_n = 1'b0;
        @(negedge clk);
        cs0 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input bit sel, input logic [1:0] a, input logic [31:0] e, input string tag);
        @(negedge clk);
        cs0 = ~sel; cs2 = sel; address = a; read_n = 1'b0;
        exp_q.push_back(e); sel_q.push_back(sel); tag_q.push_back(tag);
        @(negedge clk);
        cs0 = 1'b0; cs2 = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_rw(input bit sel, input logic [1:0] a, input logic [31:0] d,
                          input logic [31:0] e, input string tag);
        @(negedge clk);
        cs0 = ~sel; cs2 = sel; address = a; writedata = d; write_n = 1'b0; read_n = 1'b0;
        exp_q.push_back(e); sel_q.push_back(sel); tag_q.push_back(tag);
        @(negedge clk);
        cs0 = 1'b0; cs2 = 1'b0; write_n = 1'b1; read_n = 1'b1;
    endtask

    // Scoreboard: compare readdata one cycle after each read strobe.
    initial begin
        forever begin
            @(posedge clk);
            if (!read_n && (cs0 || cs2)) begin
                #1;
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [31:0] e;
                    bit          s;
                    string       t;
                    e = exp_q.pop_front();
                    s = sel_q.pop_front();
                    t = tag_q.pop_front();
                    check_eq(t, s ? rd2 : rd0, e);
                end
            end
        end
    end

    initial begin
        cs0 = 1'b0; cs2 = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 2'd0; writedata = 32'd0;
        in0 = 17'h1FFFF; in2 = 17'h00000; reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd0", rd0, 32'd0);
        check_eq("rst_irq0", 32'(irq0), 32'd0);
        check_eq("rst_rd2", rd2, 32'd0);
        check_eq("rst_irq2", 32'(irq2), 32'd0);
        reset_n = 1'b1;

        // 1: input held high through reset must not capture
        repeat (SYNC + 1) @(posedge clk);
        bus_read(1'b0, 2'd0, 32'h0001_FFFF, "t1_data");
        bus_read(1'b0, 2'd3, 32'h0000_0000, "t1_cap");
        bus_write(1'b0, 2'd2, 32'hFFFF_FFFF);
        bus_read(1'b0, 2'd2, 32'h0001_FFFF, "t1_mask");
        @(posedge clk); #1;
        check_eq("t1_irq", 32'(irq0), 32'd0);
        bus_write(1'b0, 2'd2, 32'h0000_0008);

        // 2: bit3 rise with mask, irq latency
        in0 = 17'h1FFF7;
        repeat (SYNC + 3) @(negedge clk);
        bus_read(1'b0, 2'd3, 32'h0000_0000, "t2_fall_ignored");
        in0 = 17'h1FFFF;
        for (int i = 1; i <= SYNC + 2; i++) begin
            @(posedge clk); #1;
            check_eq("t2_irq_lat", 32'(irq0), 32'((i == SYNC + 2) ? 1 : 0));
        end
        bus_read(1'b0, 2'd3, 32'h0000_0008, "t2_cap");
        bus_write(1'b0, 2'd3, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check_eq("t2_irq_clr", 32'(irq0), 32'd0);

        // 3: masked capture, then mask on/off
        bus_write(1'b0, 2'd2, 32'h0000_0000);
        in0 = 17'h1FFF7;
        repeat (SYNC + 3) @(negedge clk);
        in0 = 17'h1FFFF;
        repeat (SYNC + 4) @(negedge clk);
        check_eq("t3_irq_masked", 32'(irq0), 32'd0);
        bus_read(1'b0, 2'd3, 32'h0000_0008, "t3_cap");
        bus_write(1'b0, 2'd2, 32'h0000_0008);
        check_eq("t3_irq_pre", 32'(irq0), 32'd0);
        @(posedge clk); #1;
        check_eq("t3_irq_on", 32'(irq0), 32'd1);
        bus_write(1'b0, 2'd2, 32'h0000_0000);
        check_eq("t3_irq_hold", 32'(irq0), 32'd1);
        @(posedge clk); #1;
        check_eq("t3_irq_off", 32'(irq0), 32'd0);

        // 4: clear with writedata = 1 on capture = 9
        @(negedge clk);
        in0 = 17'h1FFFE;
        repeat (SYNC + 3) @(negedge clk);
        in0 = 17'h1FFFF;
        repeat (SYNC + 3) @(negedge clk);
        bus_read(1'b0, 2'd3, 32'h0000_0009, "t4_cap_pre");
        bus_write(1'b0, 2'd3, 32'h0000_0001);
        bus_read(1'b0, 2'd3, T4_EXP, "t4_cap_post");
        bus_write(1'b0, 2'd3, 32'hFFFF_FFFF);
        bus_read(1'b0, 2'd3, 32'h0000_0000, "t4_cap_zero");

        // 5: bit5 edge in the same cycle as clear-all
        bus_write(1'b0, 2'd2, 32'h0000_0020);
        in0 = 17'h1FFDF;
        repeat (SYNC + 3) @(negedge clk);
        in0 = 17'h1FFFF;
        repeat (SYNC) @(posedge clk);
        bus_write(1'b0, 2'd3, 32'hFFFF_FFFF);
        check_eq("t5_irq_pre", 32'(irq0), 32'd0);
        @(posedge clk); #1;
        check_eq("t5_irq_on", 32'(irq0), 32'd1);
        bus_read(1'b0, 2'd3, 32'h0000_0020, "t5_set_wins");
        check_eq("t5_irq_hold", 32'(irq0), 32'd1);
        bus_write(1'b0, 2'd3, 32'hFFFF_FFFF);
        bus_write(1'b0, 2'd2, 32'h0000_0000);

        // simultaneous read/write returns the old value; reserved reads 0
        bus_rw(1'b0, 2'd2, 32'h0000_0015, 32'h0000_0000, "rw_old");
        bus_read(1'b0, 2'd2, 32'h0000_0015, "rw_new");
        bus_write(1'b0, 2'd1, 32'hFFFF_FFFF);
        bus_read(1'b0, 2'd1, 32'h0000_0000, "rsvd0");

        // 6: any-edge instance, 4-cycle pulse with clear between edges
        bus_read(1'b1, 2'd0, 32'h0000_0000, "t6_data_lo");
        bus_write(1'b1, 2'd2, 32'h0000_0001);
        bus_read(1'b1, 2'd2, 32'h0000_0001, "t6_mask");
        bus_read(1'b1, 2'd3, 32'h0000_0000, "t6_cap0");
        in2 = 17'h00001;
        repeat (SYNC + 1) @(posedge clk);
        bus_write(1'b1, 2'd3, 32'hFFFF_FFFF);
        check_eq("t6_irq_rise", 32'(irq2), 32'd1);
        in2 = 17'h00000;
        bus_read(1'b1, 2'd3, 32'h0000_0000, "t6_cap_cleared");
        check_eq("t6_irq_off", 32'(irq2), 32'd0);
        repeat (2) @(negedge clk);
        bus_read(1'b1, 2'd3, 32'h0000_0001, "t6_cap_fall");
        check_eq("t6_irq_fall", 32'(irq2), 32'd1);
        bus_write(1'b1, 2'd0, 32'h0001_FFFF);
        bus_read(1'b1, 2'd0, 32'h0000_0000, "t6_data_ro");
        bus_read(1'b1, 2'd1, 32'h0000_0000, "t6_rsvd");

        // asynchronous reset mid-operation
        bus_read(1'b0, 2'd2, 32'h0000_0015, "pre_rst0");
        bus_read(1'b1, 2'd2, 32'h0000_0001, "pre_rst2");
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_rd0", rd0, 32'd0);
        check_eq("arst_rd2", rd2, 32'd0);
        check_eq("arst_irq2", 32'(irq2), 32'd0);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sopc_2_pio_in.md
Name: sopc_2_pio_in

Overview:
Avalon-MM slave input PIO, the read-side counterpart of the system's output PIO.
- Samples a WIDTH-bit external bus through a synchronizer and exposes it to the CPU.
- Latches selected edges in an edge-capture register.
- Raises a level interrupt on any captured edge that is enabled in the interrupt mask.
- Sits on the SOPC interconnect alongside the output PIO and uses the same 2-bit word address space.

Parameters:
WIDTH, 17, width of in_port and of every register; must be 1..32.
SYNC_STAGES, 2, flip-flop stages between in_port and the data register; must be 2..4.
EDGE_TYPE, 0, edge captured: 0 = rising, 1 = falling, 2 = any.

Ports:
clk  input  1  system clock.
reset_n  input  1  reset, asynchronous assert, active-low.
address  input  2  word address.
chipselect  input  1  slave select.
write_n  input  1  write strobe, active-low.
writedata  input  32  write data; bits [WIDTH-1:0] used.
read_n  input  1  read strobe, active-low.
in_port  input  WIDTH  external asynchronous inputs.
readdata  output  32  registered read data; upper bits zero.
irq  output  1  level interrupt, active-high.

Behaviour:
- Reset: clk and reset_n only; reset is asynchronous and active-low. While reset_n=0, all of the following are 0:
  - sync chain, data_in, prev, edge_capture, irq_mask, primed counter, readdata, irq.
- Synchronizer:
  - in_port passes through SYNC_STAGES flops; the last stage is data_in.
  - prev = data_in delayed by one clk.
  - Latency from in_port change to data_in change is SYNC_STAGES cycles.
- Edge detect (per bit):
  - rise = data_in & ~prev.
  - fall = ~data_in & prev.
  - edge = rise, fall, or rise|fall according to EDGE_TYPE.
- Priming:
  - A counter runs for SYNC_STAGES+1 cycles after reset release.
  - edge is forced to 0 until the count completes, so an input held high through reset does not capture a spurious rising edge.
  - The counter saturates and is never re-armed except by reset.
- Register map (wr = chipselect & ~write_n):
  - 0 data: read-only, returns data_in; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 irq_mask: R/W; wr loads writedata[WIDTH-1:0].
  - 3 edge_capture: read returns the register; clear behaviour on wr is given under Optional Feature.
- Edge capture, per bit, each cycle: edge_capture <= (edge_capture & ~clr) | edge.
  - Set has priority: an edge arriving in the same cycle as a clear leaves the bit at 1.
- irq: registered; irq <= |(edge_capture & irq_mask).
  - Asserts 1 cycle after the capture bit sets, 2 cycles after the edge reaches data_in.
  - Deasserts 1 cycle after a clear or mask write.
- Read:
  - readdata <= mux(address), zero-extended to 32 bits.
  - Updates every cycle with chipselect & ~read_n; otherwise holds.
  - Read latency is 1 cycle, no wait states.
  - Reading has no side effects.
- Writes complete in one cycle, no wait states.
- Simultaneous read and write of the same address: readdata returns the pre-write value.
- Reset mid-operation: all state clears immediately. Priming restarts on release.

Optional Feature:
Macro: SOPC_PIO_IN_BIT_CLEAR_EN
- Defined: a write to address 3 clears only the bits set in writedata (clr = writedata[WIDTH-1:0]). Writing 0 is a no-op.
- Undefined: any write to address 3 clears all bits (clr = all ones); writedata is ignored.
- In both cases the set-priority rule holds.

Test Plan:
1. Reset with in_port=17'h1FFFF held through release, EDGE_TYPE=0 -> edge_capture reads 0 and irq stays 0; address 0 reads 32'h0001FFFF after SYNC_STAGES+1 cycles.
2. in_port bit3 0->1, irq_mask=17'h00008 -> edge_capture=17'h00008; irq=1 exactly SYNC_STAGES+2 cycles after the in_port change.
3. Same setup, irq_mask=0 -> bit captured, irq stays 0; then write irq_mask=8 -> irq=1 the next cycle; write irq_mask=0 -> irq=0 the next cycle.
4. Clear edge_capture=17'h00009:
   - Macro defined, write 32'h1 -> reads 17'h00008.
   - Macro undefined, write 32'h1 -> reads 0.
5. A bit-5 edge lands in the same cycle as a clear-all write -> bit 5 remains 1 and irq stays asserted if that bit is masked in.
6. EDGE_TYPE=2, pulse bit0 high for 4 cycles and clear between edges -> both the rise and the fall are captured; a write to address 0 leaves the data read unchanged; address 1 reads 0.
